// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, one iteration per clock, WIDTH+1 cycles from accept to done.
// Define SIGNED_MULT_EN for two's-complement operands (magnitude iteration plus sign fix-up).
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc_hi, acc_lo;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt;
    logic [WIDTH-1:0] a_in, b_in;
    logic [2*WIDTH-1:0] result;
    logic             last_iter;

`ifdef SIGNED_MULT_EN
    logic sign;
    // The most-negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign a_in   = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
    assign b_in   = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
    assign result = sign ? -{acc_hi_nxt, acc_lo_nxt} : {acc_hi_nxt, acc_lo_nxt};
`else
    assign a_in   = multiplicand;
    assign b_in   = multiplier;
    assign result = {acc_hi_nxt, acc_lo_nxt};
`endif

    // Carry from the upper-half add is shifted back into the accumulator MSB.
    assign sum        = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign acc_hi_nxt = sum[WIDTH:1];
    assign acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    assign last_iter  = (count == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand      <= '0;
            mplier     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            count      <= '0;
            product_hi <= '0;
            product_lo <= '0;
`ifdef SIGNED_MULT_EN
            sign       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a_in;
                    mplier <= b_in;
                    acc_hi <= '0;
                    acc_lo <= '0;
                    count  <= '0;
`ifdef SIGNED_MULT_EN
                    sign   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
                end
                RUN: begin
                    acc_hi <= acc_hi_nxt;
                    acc_lo <= acc_lo_nxt;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        product_hi <= result[2*WIDTH-1:WIDTH];
                        product_lo <= result[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver pushes model products, negedge monitor checks them.
module tb_seq_multiplier;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] product_hi, product_lo;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(a), .multiplier(b),
        .busy(busy), .done(done),
        .product_hi(product_hi), .product_lo(product_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [2*W-1:0] prod; int issue; } exp_t;
    exp_t           sb[$];
    int             checks = 0, errors = 0;
    logic [2*W-1:0] last_prod = '0;
    int             busy_cnt = 0;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SIGNED_MULT_EN
        logic signed [2*W-1:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
`else
        logic [2*W-1:0] ux, uy;
        ux = {{W{1'b0}}, x};
        uy = {{W{1'b0}}, y};
        return ux * uy;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: independent of the driver, compares whatever the DUT presents.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", {product_hi, product_lo}, e.prod);
                    check("latency", 64'(cyc - e.issue), 64'(W + 1));
                    check("busy_cycles", 64'(busy_cnt), 64'(W));
                    last_prod = e.prod;
                end
                busy_cnt = 0;
            end else begin
                check("hold", {product_hi, product_lo}, last_prod);
            end
        end
    end

    // Driver tasks run in the posedge+#1 phase.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        start = 1'b1; a = x; b = y;
        e.prod = model(x, y);
        e.issue = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic ignored_start(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic mult(input logic [W-1:0] x, input logic [W-1:0] y);
        issue(x, y);
        wait_done();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hi", 64'(product_hi), 64'(0));
        check("reset_lo", 64'(product_lo), 64'(0));
        reset = 1'b0;

        mult(32'd7, 32'd6);
        mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mult(32'd0, 32'h1234);

        // start pulse during RUN must be ignored
        issue(32'd7, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        ignored_start(32'd3, 32'd3);
        wait_done();

        // reset in the middle of RUN
        issue(32'd5, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        busy_cnt = 0;
        last_prod = '0;
        @(posedge clk); #1;
        check("midrun_reset_busy", 64'(busy), 64'(0));
        check("midrun_reset_done", 64'(done), 64'(0));
        check("midrun_reset_hi", 64'(product_hi), 64'(0));
        check("midrun_reset_lo", 64'(product_lo), 64'(0));
        reset = 1'b0;

        mult(32'd2, 32'd2);
        mult(32'hFFFF_FFFD, 32'd5);
        mult(32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: x = '0;
                1: y = 32'h8000_0000;
                2: x = '1;
                default: ;
            endcase
            issue(x, y);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 25)) @(posedge clk);
                #1;
                ignored_start($urandom, $urandom);
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
